// File: rtl/jtframe_frame_window.sv
// Purpose : frame-synchronous window generator; counts vsync edges and opens CH
//           independent windows, each a start frame plus a length in frames.
// Latency : frame_pulse 3 clk after the vs pin edge; frame_cnt/win_en/win_done 1 clk later.
// Backpr. : none; arm is a level, 0 aborts and idles every channel on the next clk.
//
// Ports   : clk, rst_n (async active-low), vs (async vsync), arm (level enable),
//           start_frame[CH*CW] / win_len[CH*LW] per-channel window setup,
//           frame_cnt, frame_pulse, win_en[CH], win_done[CH].
// Option  : JTFRAME_DUMP_TASKS_EN (simulation only) logs channel-0 win_en edges.
module jtframe_frame_window #(
    parameter int CW     = 32,
    parameter int LW     = 16,
    parameter int CH     = 2,
    parameter int VS_POL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vs,
    input  logic             arm,
    input  logic [CH*CW-1:0] start_frame,
    input  logic [CH*LW-1:0] win_len,
    output logic [CW-1:0]    frame_cnt,
    output logic             frame_pulse,
    output logic [CH-1:0]    win_en,
    output logic [CH-1:0]    win_done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Level of vs between active edges; the sync chain resets to it so that
    // releasing reset never fabricates a frame.
    localparam logic VS_INACTIVE = (VS_POL == 0) ? 1'b1 : 1'b0;

    logic          vs_s1;
    logic          vs_s2;
    logic          vs_d;
    logic          vs_edge;
    logic [CW-1:0] next_frame;

    assign vs_edge    = (VS_POL == 0) ? (vs_d & ~vs_s2) : (~vs_d & vs_s2);
    assign next_frame = frame_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1       <= VS_INACTIVE;
            vs_s2       <= VS_INACTIVE;
            vs_d        <= VS_INACTIVE;
            frame_pulse <= 1'b0;
        end else begin
            vs_s1       <= vs;
            vs_s2       <= vs_s1;
            vs_d        <= vs_s2;
            frame_pulse <= vs_edge;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_pulse) begin
            frame_cnt <= next_frame;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [1:0]    st;
        logic [LW-1:0] rem;
        logic          done_q;
        logic [CW-1:0] ch_start;
        logic [LW-1:0] ch_len;
        logic          start_hit;

        assign ch_start = start_frame[i*CW +: CW];
        assign ch_len   = win_len[i*LW +: LW];
        // Compare against the value frame_cnt takes this edge, so the window
        // opens in the same cycle frame_cnt shows the start frame.
        assign start_hit = frame_pulse && (next_frame == ch_start);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st     <= ST_IDLE;
                rem    <= '0;
                done_q <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (!arm) begin
                    // Dropping arm wins over a coincident frame_pulse: no start, no done.
                    st  <= ST_IDLE;
                    rem <= '0;
                end else begin
                    case (st)
                        ST_IDLE: st <= ST_WAIT;
                        ST_WAIT: begin
                            if (start_hit) begin
                                if (ch_len != '0) begin
                                    st  <= ST_ACTIVE;
                                    rem <= ch_len;
                                end else begin
                                    st     <= ST_DONE;
                                    done_q <= 1'b1;
                                end
                            end
                        end
                        ST_ACTIVE: begin
                            if (frame_pulse) begin
                                rem <= rem - LW'(1);
                                if (rem == LW'(1)) begin
                                    st     <= ST_DONE;
                                    done_q <= 1'b1;
                                end
                            end
                        end
                        default: ; // ST_DONE holds until arm drops
                    endcase
                end
            end
        end

        assign win_en[i]   = (st == ST_ACTIVE);
        assign win_done[i] = done_q;
    end

`ifdef JTFRAME_DUMP_TASKS_EN
    logic dump_en_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dump_en_q <= 1'b0;
        end else begin
            dump_en_q <= win_en[0];
            if (win_en[0] && !dump_en_q) begin
                $display("dump on at frame %d", frame_cnt);
            end
            if (!win_en[0] && dump_en_q) begin
                $display("dump off at frame %d", frame_cnt);
            end
        end
    end
`endif

endmodule
